// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES forward MixColumns, COLS_PER_CYCLE columns per clock
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);
  localparam int N  = 4 / COLS_PER_CYCLE;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    w, w_mix;
  logic            load;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    {s0, s1, s2, s3} = col;
    return {xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3,
            xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3)};
  endfunction
  // only the column group selected by the counter is rewritten each pass
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign w_mix[127-32*c -: 32] = cnt == CW'(c / COLS_PER_CYCLE) ? mix(w[127-32*c -: 32]) : w[127-32*c -: 32];
  end
  assign in_ready  = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign data_out  = w;
  assign load      = in_valid && in_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      w     <= '0;
    end else if (load) begin
      state <= BUSY;
      cnt   <= '0;
      w     <= data_in;
    end else if (state == BUSY) begin
      w     <= w_mix;
      cnt   <= cnt + 1'b1;
      state <= cnt == CW'(N - 1) ? DONE : BUSY;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed and randomized checks of mix_columns_seq for 1, 2 and 4 columns per clock
module tb_mix_columns_seq;
  logic         clk = 0, reset = 1;
  logic         iv[3], ordy[3], ir[3], ov[3];
  logic [127:0] din[3], dout[3];
  int           passed = 0, total = 0;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(1 << i)) dut (
      .clk(clk), .reset(reset), .in_valid(iv[i]), .in_ready(ir[i]), .data_in(din[i]),
      .out_valid(ov[i]), .out_ready(ordy[i]), .data_out(dout[i]));
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // GF(2^8) product by shift-and-add with the AES polynomial
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // circulant matrix product per column; inv selects InvMixColumns
  function automatic logic [127:0] mixm(logic [127:0] s, bit inv);
    logic [7:0]   co[4];
    logic [7:0]   acc;
    logic [127:0] o = '0;
    if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc ^= gmul(co[(k - r + 4) % 4], s[127-32*c-8*k -: 8]);
        o[127-32*c-8*r -: 8] = acc;
      end
    return o;
  endfunction

  // accept s on DUT d and return the number of edges after the accept edge until out_valid
  task automatic start(input int d, input logic [127:0] s, output int lat);
    @(negedge clk);
    iv[d] = 1; din[d] = s; ordy[d] = 0;
    #1 chk($sformatf("accept_ready d%0d", d), ir[d], 1);
    @(negedge clk);
    iv[d] = 0; lat = 0;
    while (!ov[d] && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic run(input int d, input logic [127:0] s, input logic [127:0] exp);
    int lat;
    start(d, s, lat);
    chk($sformatf("latency d%0d", d), lat, 4 >> d);
    chk($sformatf("data d%0d", d), dout[d], exp);
    ordy[d] = 1;
    @(negedge clk);
    ordy[d] = 0;
    chk($sformatf("consumed d%0d", d), ov[d], 0);
  endtask

  task automatic b2b(input int d, input logic [127:0] a, input logic [127:0] b);
    int n = 4 >> d, nres = 0, e0 = -1, e1 = -1;
    logic [127:0] r0 = '0, r1 = '0;
    @(negedge clk);
    iv[d] = 1; ordy[d] = 1; din[d] = a;
    for (int e = 0; e < 2 * n + 6; e++) begin
      @(negedge clk);
      if (e == 0) din[d] = b;
      if (ov[d]) begin
        if (nres == 0) begin r0 = dout[d]; e0 = e; end
        else if (nres == 1) begin r1 = dout[d]; e1 = e; end
        nres++;
      end
      if (nres > 0 && e > e0) iv[d] = 0;
    end
    ordy[d] = 0; iv[d] = 0;
    chk($sformatf("b2b count d%0d", d), nres, 2);
    chk($sformatf("b2b first_at d%0d", d), e0, n);
    chk($sformatf("b2b second_at d%0d", d), e1, 2 * n + 1);
    chk($sformatf("b2b first d%0d", d), r0, mixm(a, 0));
    chk($sformatf("b2b second d%0d", d), r1, mixm(b, 0));
  endtask

  task automatic rnd(input int d, input int count);
    logic [127:0] q[$];
    logic [127:0] s;
    int sent = 0, got = 0, cyc = 0;
    bit acc = 0;
    while (got < count && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (acc) iv[d] = 0;
      acc = 0;
      ordy[d] = $urandom_range(0, 3) != 0;
      if (!iv[d] && sent < count && $urandom_range(0, 3) != 0) begin
        iv[d] = 1;
        din[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      if (ov[d] && ordy[d]) begin
        if (q.size() == 0) chk($sformatf("rnd unexpected_result d%0d", d), ov[d], 0);
        else begin
          s = q.pop_front();
          chk($sformatf("rnd data d%0d #%0d", d, got), dout[d], mixm(s, 0));
          chk($sformatf("rnd inverse d%0d #%0d", d, got), mixm(dout[d], 1), s);
        end
        got++;
      end
      if (iv[d] && ir[d]) begin q.push_back(din[d]); sent++; acc = 1; end
    end
    iv[d] = 0; ordy[d] = 0;
    chk($sformatf("rnd count d%0d", d), got, count);
  endtask

  initial begin
    int lat;
    logic [127:0] held;
    for (int i = 0; i < 3; i++) begin iv[i] = 0; ordy[i] = 0; din[i] = '0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset out_valid d%0d", i), ov[i], 0);
      chk($sformatf("reset data_out d%0d", i), dout[i], '0);
      chk($sformatf("reset in_ready d%0d", i), ir[i], 1);
    end
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("post_reset in_ready d%0d", i), ir[i], 1);

    for (int d = 0; d < 3; d++) begin
      run(d, V1, E1);
      run(d, V2, E2);
    end

    start(0, V1, lat);
    held = dout[0];
    chk("bp data_before", held, E1);
    for (int k = 0; k < 10; k++) begin
      iv[0] = k[0]; din[0] = V2;
      #1;
      chk($sformatf("bp out_valid %0d", k), ov[0], 1);
      chk($sformatf("bp in_ready %0d", k), ir[0], 0);
      chk($sformatf("bp data %0d", k), dout[0], E1);
      @(negedge clk);
    end
    iv[0] = 0; ordy[0] = 1;
    @(negedge clk);
    ordy[0] = 0;
    chk("bp released in_ready", ir[0], 1);
    repeat (6) @(negedge clk);
    chk("bp no_stray_accept", ov[0], 0);

    for (int d = 0; d < 3; d++) b2b(d, V1, V2);

    @(negedge clk);
    iv[0] = 1; din[0] = V1;
    @(negedge clk);
    iv[0] = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    chk("midreset out_valid", ov[0], 0);
    chk("midreset data_out", dout[0], '0);
    chk("midreset in_ready", ir[0], 1);
    @(negedge clk);
    reset = 0;
    repeat (6) @(negedge clk);
    chk("midreset no_pulse", ov[0], 0);
    run(0, V2, E2);

    for (int d = 0; d < 3; d++) rnd(d, 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
